// File: rtl/mem_io_pkg.sv
// Shared constants for the CPU memory-side bus stage: I/O register offsets,
// STATUS bit positions, the default I/O base and the read-source select type.
package mem_io_pkg;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

  localparam int unsigned IO_LED    = 0;
  localparam int unsigned IO_SW     = 1;
  localparam int unsigned IO_TIMER  = 2;
  localparam int unsigned IO_STATUS = 3;

  localparam int unsigned ST_EXPIRED = 0;
  localparam int unsigned ST_ENABLE  = 1;

  typedef enum logic {
    RD_RAM = 1'b0,
    RD_IO  = 1'b1
  } rd_sel_e;

endpackage

// File: rtl/io_timer.sv
// Prescaled down-counting timer with reload, enable and a sticky expired flag.
// State changes on the rising edge only; software strobes take effect in the same cycle.
module io_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 50000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_we_i,
  input  logic             en_val_i,
  input  logic             clr_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] count_o,
  output logic             enable_o,
  output logic             expired_o
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             enable_q, enable_d;
  logic             expired_q, expired_d;
  logic             tick;

  always_comb begin
    tick      = enable_q && (pre_q == PRE_LAST);
    pre_d     = pre_q;
    count_d   = count_q;
    reload_d  = reload_q;
    enable_d  = enable_q;
    expired_d = expired_q;

    if (enable_q) pre_d = tick ? '0 : pre_q + PW'(1);
    if (load_i || start_i) pre_d = '0;

    // A software load overrides a coincident tick, including its expiry.
    if (load_i) begin
      count_d  = load_val_i;
      reload_d = load_val_i;
    end else if (tick) begin
      count_d = (count_q == '0) ? reload_q : count_q - WIDTH'(1);
    end

    if (tick && !load_i && (count_q == '0)) expired_d = 1'b1;
    else if (clr_i)                         expired_d = 1'b0;

    if (en_we_i) enable_d = en_val_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q     <= '0;
      count_q   <= '0;
      reload_q  <= '0;
      enable_q  <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      enable_q  <= enable_d;
      expired_q <= expired_d;
    end
  end

  assign count_o   = count_q;
  assign enable_o  = enable_q;
  assign expired_o = expired_q;

endmodule

// File: rtl/mem_io_bus.sv
// CPU memory-side decode to block RAM or a small I/O window (LEDs, switches, timer).
// Read data returns exactly one cycle after the address for both targets; no stalls.
module mem_io_bus
  import mem_io_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] IO_BASE   = WIDTH'(IO_BASE_DEFAULT),
  parameter int               SW_WIDTH  = 10,
  parameter int               LED_WIDTH = 10,
  parameter int               PRESCALE  = 50000
) (
  input  logic                 clk50MHz,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     mem_addr,
  input  logic [WIDTH-1:0]     writedata,
  input  logic                 memwrite,
  output logic [WIDTH-1:0]     mem_out,
  output logic [WIDTH-1:0]     bram_addr,
  output logic [WIDTH-1:0]     bram_data,
  output logic                 bram_we,
  input  logic [WIDTH-1:0]     bram_q,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [LED_WIDTH-1:0] leds
);

  localparam logic [WIDTH-1:0] OFF_LED    = WIDTH'(IO_LED);
  localparam logic [WIDTH-1:0] OFF_SW     = WIDTH'(IO_SW);
  localparam logic [WIDTH-1:0] OFF_TIMER  = WIDTH'(IO_TIMER);
  localparam logic [WIDTH-1:0] OFF_STATUS = WIDTH'(IO_STATUS);

  logic                 is_io;
  logic [WIDTH-1:0]     offset;
  logic                 io_wr;
  logic                 led_wr, timer_wr, status_wr;

  logic [LED_WIDTH-1:0] leds_q, leds_d;
  logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
  rd_sel_e              rd_sel_q, rd_sel_d;
  logic [WIDTH-1:0]     io_rdata_q, io_rdata_d;

  logic [WIDTH-1:0]     tmr_count;
  logic                 tmr_enable, tmr_expired;

  assign is_io     = (mem_addr >= IO_BASE);
  assign offset    = mem_addr - IO_BASE;
  assign io_wr     = memwrite && is_io;
  assign led_wr    = io_wr && (offset == OFF_LED);
  assign timer_wr  = io_wr && (offset == OFF_TIMER);
  assign status_wr = io_wr && (offset == OFF_STATUS);

  assign bram_addr = mem_addr;
  assign bram_data = writedata;
  assign bram_we   = memwrite && !is_io;

  io_timer #(
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk_i      (clk50MHz),
    .rst_ni     (reset),
    .load_i     (timer_wr),
    .load_val_i (writedata),
    .en_we_i    (status_wr),
    .en_val_i   (writedata[ST_ENABLE]),
    .clr_i      (status_wr && writedata[ST_EXPIRED]),
    .start_i    (status_wr && writedata[ST_ENABLE] && !tmr_enable),
    .count_o    (tmr_count),
    .enable_o   (tmr_enable),
    .expired_o  (tmr_expired)
  );

  // Mux reads pre-write state, so a same-cycle write is seen only on the next read.
  always_comb begin
    io_rdata_d = '0;
    leds_d     = leds_q;
    rd_sel_d   = is_io ? RD_IO : RD_RAM;
    if (led_wr) leds_d = writedata[LED_WIDTH-1:0];
    if (is_io) begin
      case (offset)
        OFF_LED:    io_rdata_d = WIDTH'(leds_q);
        OFF_SW:     io_rdata_d = WIDTH'(sw_sync_q);
        OFF_TIMER:  io_rdata_d = tmr_count;
        OFF_STATUS: begin
          io_rdata_d[ST_ENABLE]  = tmr_enable;
          io_rdata_d[ST_EXPIRED] = tmr_expired;
        end
        default:    io_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk50MHz or negedge reset) begin
    if (!reset) begin
      leds_q     <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      rd_sel_q   <= RD_RAM;
      io_rdata_q <= '0;
    end else begin
      leds_q     <= leds_d;
      sw_meta_q  <= switches;
      sw_sync_q  <= sw_meta_q;
      rd_sel_q   <= rd_sel_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  assign mem_out = (rd_sel_q == RD_IO) ? io_rdata_q : bram_q;
  assign leds    = leds_q;

endmodule

// File: tb/tb_mem_io_bus.sv
// Randomized and directed bench for mem_io_bus against a behavioural memory/I-O model.
module tb_mem_io_bus;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam int          P    = 4;

  logic        clk50MHz = 1'b0;
  logic        reset    = 1'b0;
  logic [15:0] mem_addr = '0, writedata = '0;
  logic        memwrite = 1'b0;
  logic [15:0] mem_out, bram_addr, bram_data, bram_q;
  logic        bram_we;
  logic [9:0]  switches = '0;
  logic [9:0]  leds;

  int n_cmp = 0;
  int n_bad = 0;
  logic we_seen;

  always #5 clk50MHz = ~clk50MHz;

  mem_io_bus #(.WIDTH(16), .IO_BASE(BASE), .SW_WIDTH(10), .LED_WIDTH(10), .PRESCALE(P)) dut (
    .clk50MHz (clk50MHz), .reset (reset), .mem_addr (mem_addr), .writedata (writedata),
    .memwrite (memwrite), .mem_out (mem_out), .bram_addr (bram_addr), .bram_data (bram_data),
    .bram_we (bram_we), .bram_q (bram_q), .switches (switches), .leds (leds)
  );

  // Block RAM port A environment: synchronous read, read-old-data on write.
  logic [15:0] env_ram [0:65535];
  always @(posedge clk50MHz) begin
    if (bram_we) env_ram[bram_addr] <= bram_data;
    bram_q <= env_ram[bram_addr];
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: register-level view of the I/O window plus a RAM image.
  logic [15:0] model_ram [0:63];
  logic [9:0]  leds_m = '0, sw1_m = '0, sw2_m = '0;
  logic [15:0] cnt_m = '0, rld_m = '0, exp_out = '0;
  logic        en_m = 1'b0, expd_m = 1'b0, follow_q = 1'b1;
  int          pre_m = 0;

  initial forever begin
    @(posedge clk50MHz or negedge reset);
    if (!reset) begin
      leds_m = '0; sw1_m = '0; sw2_m = '0; cnt_m = '0; rld_m = '0;
      en_m = 1'b0; expd_m = 1'b0; pre_m = 0; follow_q = 1'b1;
    end else begin
      int  off;
      logic io, tick, ld, st;
      io   = (mem_addr >= BASE);
      off  = int'(mem_addr) - int'(BASE);
      if (io) begin
        case (off)
          0:       exp_out = {6'b0, leds_m};
          1:       exp_out = {6'b0, sw2_m};
          2:       exp_out = cnt_m;
          3:       exp_out = {14'b0, en_m, expd_m};
          default: exp_out = 16'h0000;
        endcase
      end else begin
        exp_out = model_ram[mem_addr[5:0]];
      end
      tick = en_m && (pre_m == P - 1);
      ld   = memwrite && io && (off == 2);
      st   = memwrite && io && (off == 3);
      if (tick && !ld && cnt_m == 0) expd_m = 1'b1;
      else if (st && writedata[0])   expd_m = 1'b0;
      if (ld) begin cnt_m = writedata; rld_m = writedata; end
      else if (tick) cnt_m = (cnt_m == 0) ? rld_m : cnt_m - 16'd1;
      if (ld || (st && writedata[1] && !en_m)) pre_m = 0;
      else if (en_m) pre_m = (pre_m + 1) % P;
      if (st) en_m = writedata[1];
      if (memwrite && io && off == 0) leds_m = writedata[9:0];
      if (memwrite && !io) model_ram[mem_addr[5:0]] = writedata;
      sw2_m = sw1_m;
      sw1_m = switches;
      follow_q = 1'b0;
    end
  end

  // Compare process: registered outputs at the falling edge, decode after inputs settle.
  initial forever begin
    @(negedge clk50MHz);
    if (follow_q) chk("mem_out_in_reset", mem_out, bram_q);
    else          chk("mem_out", mem_out, exp_out);
    chk("leds", {6'b0, leds}, {6'b0, leds_m});
    #2;
    chk("bram_we", {15'b0, bram_we}, {15'b0, memwrite && (mem_addr < BASE)});
    chk("bram_addr", bram_addr, mem_addr);
    chk("bram_data", bram_data, writedata);
  end

  task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w);
    @(negedge clk50MHz);
    #1;
    mem_addr = a; writedata = d; memwrite = w;
    #1;
    we_seen = bram_we;
    @(posedge clk50MHz);
    #2;
  endtask

  task automatic do_reset();
    memwrite = 1'b0;
    @(negedge clk50MHz);
    #3 reset = 1'b0;
    @(negedge clk50MHz);
    #3 reset = 1'b1;
  endtask

  initial begin
    logic [15:0] a, d;
    logic        w;
    int          r;
    #1;
    chk("reset_leds", {6'b0, leds}, 16'h0000);
    chk("reset_mem_out", mem_out, bram_q);
    @(negedge clk50MHz);
    #3 reset = 1'b1;

    for (int i = 0; i < 64; i++) cyc(16'(i), 16'($urandom), 1'b1);

    cyc(16'h0010, 16'h1234, 1'b1); chk("ram_wr_we", {15'b0, we_seen}, 16'h0001);
    cyc(16'h0010, 16'h0000, 1'b0); chk("ram_rd_data", mem_out, 16'h1234);
    chk("ram_rd_we", {15'b0, we_seen}, 16'h0000);
    cyc(16'hFF00, 16'h03FF, 1'b1); chk("io_wr_we", {15'b0, we_seen}, 16'h0000);
    chk("leds_written", {6'b0, leds}, 16'h03FF);
    cyc(16'hFF00, 16'h0000, 1'b0); chk("rd_led", mem_out, 16'h03FF);
    cyc(16'hFF07, 16'hBEEF, 1'b1);
    cyc(16'hFF07, 16'h0000, 1'b0); chk("rd_unmapped", mem_out, 16'h0000);

    switches = 10'h2A5;
    cyc(16'hFF01, 16'h0, 1'b0); chk("sw_edge1", mem_out, 16'h0000);
    cyc(16'hFF01, 16'h0, 1'b0); chk("sw_edge2", mem_out, 16'h0000);
    cyc(16'hFF01, 16'h0, 1'b0); chk("sw_edge3", mem_out, 16'h02A5);

    // Timer: period of reload+1 ticks, 4 cycles per tick.
    do_reset();
    cyc(16'hFF02, 16'd2, 1'b1);
    cyc(16'hFF03, 16'b10, 1'b1);
    repeat (10) cyc(16'hFF03, 16'h0, 1'b0);
    chk("tmr_running", mem_out, 16'h0002);
    cyc(16'hFF02, 16'h0, 1'b0); chk("tmr_count0", mem_out, 16'h0000);
    cyc(16'hFF03, 16'h0, 1'b0); chk("tmr_pre_expiry", mem_out, 16'h0002);
    cyc(16'hFF03, 16'h0, 1'b0); chk("tmr_expired", mem_out, 16'h0003);
    cyc(16'hFF02, 16'h0, 1'b0); chk("tmr_reload", mem_out, 16'h0002);

    // Clear on the expiry cycle loses; clear one cycle later wins.
    do_reset();
    cyc(16'hFF02, 16'd2, 1'b1);
    cyc(16'hFF03, 16'b10, 1'b1);
    repeat (11) cyc(16'hFF03, 16'h0, 1'b0);
    cyc(16'hFF03, 16'b11, 1'b1); chk("race_old", mem_out, 16'h0002);
    cyc(16'hFF03, 16'b11, 1'b1); chk("race_set_wins", mem_out, 16'h0003);
    cyc(16'hFF03, 16'h0, 1'b0);  chk("race_cleared", mem_out, 16'h0002);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      a = 16'($urandom_range(0, 63));
      else if (r < 95) a = BASE + 16'($urandom_range(0, 3));
      else             a = BASE + 16'($urandom_range(4, 255));
      w = ($urandom_range(0, 3) == 0);
      d = 16'($urandom);
      if (a == BASE + 16'd2) d = 16'($urandom_range(0, 3));
      if (a == BASE + 16'd3) d = {14'b0, ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 30) == 0) switches = 10'($urandom);
      cyc(a, d, w);
    end

    // Asynchronous reset while the timer runs.
    cyc(16'hFF00, 16'h0155, 1'b1);
    cyc(16'hFF02, 16'd5, 1'b1);
    cyc(16'hFF03, 16'b10, 1'b1);
    repeat (6) cyc(16'hFF02, 16'h0, 1'b0);
    chk("leds_pre_reset", {6'b0, leds}, 16'h0155);
    mem_addr = 16'h0000; memwrite = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_leds", {6'b0, leds}, 16'h0000);
    chk("async_rst_mem_out", mem_out, bram_q);
    @(negedge clk50MHz);
    #3 reset = 1'b1;
    cyc(16'hFF02, 16'h0, 1'b0); chk("rst_count", mem_out, 16'h0000);
    cyc(16'hFF03, 16'h0, 1'b0); chk("rst_status", mem_out, 16'h0000);
    cyc(16'hFF00, 16'h0, 1'b0); chk("rst_led_rd", mem_out, 16'h0000);

    @(negedge clk50MHz);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_io_bus.md
Name: mem_io_bus

Overview:
- Memory-side bus stage directly downstream of the CPU memory port (mem_addr, writedata, memwrite) and upstream of its mem_out input.
- Decodes each CPU access to either block RAM (port A) or a small memory-mapped I/O window.
- The I/O window holds an LED register, synchronized switch inputs and a prescaled down-counting timer.
- Returns read data with exactly 1-cycle latency for both targets, so the controller's load timing does not depend on the target.

Parameters:
- WIDTH, 16, data and address width.
- IO_BASE, 16'hFF00, first I/O address; every address >= IO_BASE is I/O.
- SW_WIDTH, 10, switch input width.
- LED_WIDTH, 10, LED output width.
- PRESCALE, 50000, clk50MHz cycles per timer tick (1 ms); minimum 2.

Ports:
- clk50MHz  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_addr  in  WIDTH  CPU address.
- writedata  in  WIDTH  CPU write data.
- memwrite  in  1  CPU write enable.
- mem_out  out  WIDTH  read data to the CPU; valid 1 cycle after the address.
- bram_addr  out  WIDTH  RAM port A address.
- bram_data  out  WIDTH  RAM port A write data.
- bram_we  out  1  RAM port A write enable.
- bram_q  in  WIDTH  RAM port A read data; synchronous, 1-cycle latency.
- switches  in  SW_WIDTH  asynchronous board switches.
- leds  out  LED_WIDTH  LED register.

Behaviour:

Reset (asynchronous, while reset=0):
- leds=0, timer count=0, timer reload=0, enable=0, expired=0.
- Switch synchronizer flops=0, prescaler=0.
- rd_sel=RAM, io_rdata=0, so mem_out reads as bram_q.

RAM decode (combinational):
- is_io = (mem_addr >= IO_BASE).
- bram_addr=mem_addr and bram_data=writedata, unconditionally.
- bram_we = memwrite & ~is_io. RAM is never written by an I/O access.

Read path:
- At each edge, rd_sel <= is_io.
- At each edge, io_rdata <= the I/O read mux for the current address.
- mem_out = rd_sel ? io_rdata : bram_q.
- Latency is 1 cycle for every address. Back-to-back accesses to mixed targets are legal every cycle.

I/O map (offset = mem_addr - IO_BASE):
- 0 LED: read returns {0, leds}. Write sets leds <= writedata[LED_WIDTH-1:0].
- 1 SW: read returns {0, sw_sync}, the output of a 2-flop synchronizer. Writes are ignored.
- 2 TIMER: read returns the current count. Write sets reload <= writedata and count <= writedata, and clears the prescaler.
- 3 STATUS: read returns {14'b0, enable, expired}.
  - Write sets enable <= writedata[1].
  - If writedata[0]=1, expired is cleared.
  - If writedata[1]=1 while enable=0, the prescaler is also cleared.
- 4 and above: reads return 0; writes are ignored.
- An I/O read returns the value before a write to the same address in the same cycle (old value).

Timer (sub-module io_timer):
- While enable=1, the prescaler counts 0..PRESCALE-1. tick is asserted on the cycle it equals PRESCALE-1, and the prescaler wraps to 0.
- On tick with count != 0: count <= count-1.
- On tick with count == 0: count <= reload and expired <= 1. The period is therefore reload+1 ticks.
- While enable=0, the prescaler and count hold.
- Expiry and a STATUS write-1-clear in the same cycle: expired ends at 1 (set wins).
- A TIMER write and a tick in the same cycle: the write wins, and expired is unchanged by that tick.
- expired is sticky until cleared by software or reset.

Reset mid-operation:
- All state returns to its reset values immediately.
- A RAM write in flight is dropped, because bram_we follows memwrite and the CPU is also held in reset.

Decomposition:
- Shared package mem_io_pkg holds:
  - Offset constants IO_LED=0, IO_SW=1, IO_TIMER=2, IO_STATUS=3.
  - STATUS bit indices ST_EXPIRED=0, ST_ENABLE=1.
  - The default IO_BASE.
- One sub-module, io_timer, contains the prescaler, count, reload, enable and expired state. Its inputs are a load strobe, load value, enable-write, clear strobe and a start strobe for the prescaler clear.
- Decode, the switch synchronizer, the LED register and the read mux stay in mem_io_bus.

Test Plan:
- RAM pass-through:
  - memwrite=1, addr 16'h0010, data 16'h1234: bram_we=1 in the same cycle.
  - Then read 16'h0010: mem_out=16'h1234 exactly 1 cycle after the address, with bram_we=0.
- I/O isolation:
  - Write 16'h03FF to 16'hFF00: bram_we stays 0 and leds=10'h3FF the following cycle.
  - Read 16'hFF00 -> 16'h03FF.
  - Read 16'hFF07 -> 16'h0000.
- Switch sync:
  - Set switches=10'h2A5 asynchronously: a read of 16'hFF01 returns 16'h02A5 only from the 3rd edge onward, and returns the old value before that.
- Timer (PRESCALE=4):
  - Write 2 to 16'hFF02, then 16'b10 to 16'hFF03.
  - expired=1 after 12 cycles (3 ticks); count reloads to 2.
  - A read of 16'hFF03 returns 16'h0003.
- Clear/set race:
  - Write 16'b11 to 16'hFF03 on the exact expiry cycle: expired reads 1.
  - A write of 16'b11 one cycle later: expired reads 0.
- Async reset mid-run:
  - Pull reset low between edges while the timer is running and leds=10'h155: leds, count and STATUS read 0 immediately without a clock edge.
  - mem_out follows bram_q.
